sd_cmd_sender: RTL and testbench
================================

# sd_cmd_sender

SPI-mode SD command engine: frames a 48-bit SD command, shifts it out on MOSI, polls MISO for the R1 response byte, then releases the card. It sits directly upstream of the `sd_delay` timer. Every SCLK half-period is timed by one `delay_start`/`delay_finish` handshake with that timer. Toward the card-init and block-read controllers it uses the same level `start` / sticky `finish` handshake that the timer uses.

## Interface
- `DELAY_W`, 4: width of `delay_times`; must match the timer's `COUNT_SIZE`.
- `HALF_TIMES`, 4: value driven on `delay_times` for every SCLK half-period.
- `RESP_POLL`, 8: maximum response bytes clocked before timeout (1..255).

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level request; accepted only in IDLE.
- `finish` out 1: command complete; sticky until the next accepted `start`.
- `cmd_index` in 6: SD command index, sampled at accept.
- `cmd_arg` in 32: argument, sampled at accept.
- `cmd_crc` in 7: CRC7, sampled at accept.
- `resp` out 8: R1 byte, valid while `finish`=1.
- `timeout` out 1: no R1 within `RESP_POLL` bytes, valid while `finish`=1.
- `sd_cs_n` out 1: card select, active low.
- `sd_sclk` out 1: SPI clock, mode 0.
- `sd_mosi` out 1: data to card.
- `sd_miso` in 1: data from card.
- `delay_start` out 1: timer request.
- `delay_times` out DELAY_W: constant `HALF_TIMES`.
- `delay_finish` in 1: timer done.

## Operation
- Reset values: `finish`=0, `resp`=8'hFF, `timeout`=0, `sd_cs_n`=1, `sd_sclk`=0, `sd_mosi`=1, `delay_start`=0. Reset mid-command aborts immediately to IDLE with these values.
- States:
  - IDLE: if `start`=1, latch frame = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1}, clear `finish`/`timeout`, go CS_SETUP.
  - CS_SETUP: drive `sd_cs_n`=0, wait one half-period, go TX_LO.
  - TX_LO: `sd_sclk`=0, `sd_mosi`=frame MSB; wait one half, go TX_HI.
  - TX_HI: `sd_sclk`=1; sample nothing; wait one half; shift frame left. After bit 48 go RX_LO, else TX_LO.
  - RX_LO: `sd_sclk`=0, `sd_mosi`=1; wait one half, go RX_HI.
  - RX_HI: `sd_sclk`=1; shift `sd_miso` into the rx byte on entry; wait one half. After 8 bits, check the byte:
    - MSB=0: `resp`=byte, go CS_HOLD.
    - byte count = `RESP_POLL`: `resp`=8'hFF, `timeout`=1, go CS_HOLD.
    - otherwise: back to RX_LO.
  - CS_HOLD: `sd_sclk`=0, wait one half, `sd_cs_n`=1, go TRAIL.
  - TRAIL: 8 SCLK cycles with CS high and MOSI high, then DONE.
  - DONE: `finish`=1; when `start`=0, go IDLE. `finish` stays 1 in IDLE.
- `start` high again in IDLE starts a new command on that cycle. A `start` drop mid-command is ignored.
- Half-period wait sub-handshake:
  1. Raise `delay_start`.
  2. Ignore `delay_finish` until it has been seen low once; the timer's finish from the previous wait is stale.
  3. On the following `delay_finish`=1, the half is complete.
  4. Drop `delay_start` for exactly one cycle before the next request.
- Responses are byte-aligned polling only.

## Timing
- Half-period H = timer round trip + 1 gap cycle, with `delay_times`=`HALF_TIMES`. No cycle-fixed SCLK frequency is implied.
- Command length: 1 + 96 + 16·k + 1 + 16 half-periods, where k is the number of response bytes polled (1..`RESP_POLL`).
- `finish` rises 1 cycle after the last TRAIL half completes.
- `resp`/`timeout` update in the same cycle as the final RX byte decision and hold until the next accept.
- `sd_mosi` changes only while `sd_sclk`=0. MISO is sampled on the rising-edge cycle.

## Structure
- Shared `sd_pkg` holds:
  - state encoding constants;
  - `SD_FRAME_W`=48 and `SD_START_BITS`=2'b01;
  - R1 idle value 8'hFF.
- One natural sub-module, `sd_half_wait`, implements the `delay_start`/`delay_finish` sub-handshake: inputs `go`, `delay_finish`; outputs `delay_start`, `done` pulse.
- The timer itself (`sd_delay`) is instantiated by the parent, not inside this block.

## Test plan
- CMD0 (index 0, arg 0, crc 7'h4A), card model returns 8'h01 on 2nd byte → MOSI stream 40 00 00 00 00 95, `resp`=8'h01, `timeout`=0, `finish`=1, 2 bytes polled.
- Card holds MISO=1 → after 8 polled bytes, `resp`=8'hFF and `timeout`=1. Total SCLK rising edges = 48 + 64 + 8.
- `start` held high after `finish` → no second command. Drop `start` 3 cycles, raise again → `finish` clears, new frame sent.
- `rst` asserted mid-TX at bit 20 → next cycle `sd_cs_n`=1, `sd_sclk`=0, `sd_mosi`=1, `delay_start`=0, state IDLE.
- Timer model with stale `delay_finish`=1 at request → block waits for the low-then-high transition. No SCLK half is shorter than the timer latency.
- CMD8 arg 32'h000001AA crc 7'h43, response 8'h01 → MOSI 48 08 00 00 01 AA 87. MOSI stable across every SCLK high phase.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and types for the SPI-mode SD command path.
//   - sd_state_e : command engine state encoding (also exported for debug)
//   - SD_FRAME_W / SD_START_BITS : 48-bit command frame layout
//   - SD_R1_IDLE : value of the R1 register when no response has been taken
//   - sd_frame() : assembles {start bits, index, argument, CRC7, end bit}
package sd_pkg;

    localparam int         SD_FRAME_W    = 48;
    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic [7:0] SD_R1_IDLE    = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CS_SETUP = 4'd1,
        ST_TX_LO    = 4'd2,
        ST_TX_HI    = 4'd3,
        ST_RX_LO    = 4'd4,
        ST_RX_HI    = 4'd5,
        ST_CS_HOLD  = 4'd6,
        ST_TRAIL_LO = 4'd7,
        ST_TRAIL_HI = 4'd8,
        ST_DONE     = 4'd9
    } sd_state_e;

    function automatic logic [SD_FRAME_W-1:0] sd_frame(
        input logic [5:0]  index,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        return {SD_START_BITS, index, arg, crc, 1'b1};
    endfunction

endpackage

// File: rtl/sd_half_wait.sv
// sd_half_wait: times one SCLK half-period through the external sd_delay timer.
//   clk, rst      : clock, synchronous active-high reset
//   go            : level, high while the engine wants a half-period timed
//   delay_finish  : timer done flag (sticky on the timer side)
//   delay_start   : timer request
//   done          : one-cycle pulse when the current half-period has elapsed
//
// The timer's finish flag is still high from the previous half when a new
// request is raised, so a half only completes once finish has been seen low
// and then high again. delay_start drops for exactly one cycle after each
// completed half, which lets the timer re-arm before the next request.
module sd_half_wait
    import sd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic delay_finish,
    output logic delay_start,
    output logic done
);

    logic seen_low;

    assign done = delay_start && seen_low && delay_finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_start <= 1'b0;
            seen_low    <= 1'b0;
        end else if (delay_start) begin
            if (done) begin
                delay_start <= 1'b0;
                seen_low    <= 1'b0;
            end else if (!delay_finish) begin
                seen_low <= 1'b1;
            end
        end else if (go) begin
            delay_start <= 1'b1;
            seen_low    <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_cmd_sender.sv
// sd_cmd_sender: SPI-mode (mode 0) SD command engine. Frames a 48-bit command,
// shifts it out on MOSI, polls MISO for the R1 byte, then releases the card
// with 8 trailing clocks.
//   clk, rst                     : clock, synchronous active-high reset
//   start / finish               : level request accepted in IDLE; finish is
//                                  sticky from completion until the next
//                                  accepted start
//   cmd_index, cmd_arg, cmd_crc  : command fields, sampled at accept
//   resp, timeout                : R1 byte and poll timeout, valid with finish
//   sd_cs_n, sd_sclk, sd_mosi    : SPI outputs to the card
//   sd_miso                      : SPI input from the card
//   delay_start, delay_times,
//   delay_finish                 : half-period timer handshake (sd_delay)
//   fsm_state                    : current engine state, for observation
//
// Handshake: the caller holds start high to request a command; it is taken
// only in IDLE. finish rises when the command is over and stays high until
// start is accepted again. A start drop mid-command has no effect; while
// start stays high in DONE no new command begins.
module sd_cmd_sender
    import sd_pkg::*;
#(
    parameter int DELAY_W    = 4,
    parameter int HALF_TIMES = 4,
    parameter int RESP_POLL  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               finish,
    input  logic [5:0]         cmd_index,
    input  logic [31:0]        cmd_arg,
    input  logic [6:0]         cmd_crc,
    output logic [7:0]         resp,
    output logic               timeout,
    output logic               sd_cs_n,
    output logic               sd_sclk,
    output logic               sd_mosi,
    input  logic               sd_miso,
    output logic               delay_start,
    output logic [DELAY_W-1:0] delay_times,
    input  logic               delay_finish,
    output sd_state_e          fsm_state
);

    sd_state_e             state;
    sd_state_e             state_next;
    logic [SD_FRAME_W-1:0] frame;
    logic [5:0]            bit_cnt;
    logic [2:0]            rx_bits;
    logic [7:0]            rx_byte;
    logic                  rx_taken;
    logic [7:0]            byte_cnt;
    logic [2:0]            trail_cnt;
    logic                  go;
    logic                  half_done;
    logic                  last_tx_bit;
    logic                  last_poll;

    assign delay_times = DELAY_W'(HALF_TIMES);
    assign fsm_state   = state;
    assign last_tx_bit = (bit_cnt == 6'(SD_FRAME_W - 1));
    assign last_poll   = (byte_cnt == 8'(RESP_POLL - 1));

    sd_half_wait u_half_wait (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .delay_finish (delay_finish),
        .delay_start  (delay_start),
        .done         (half_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pins are a pure decode of the state register and the frame MSB, so
    // MOSI only moves on the same edge that drops SCLK.
    always_comb begin
        state_next = state;
        go         = 1'b0;
        sd_cs_n    = 1'b1;
        sd_sclk    = 1'b0;
        sd_mosi    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                sd_cs_n = 1'b0;
                go      = 1'b1;
                if (half_done) state_next = ST_TX_LO;
            end
            ST_TX_LO: begin
                sd_cs_n = 1'b0;
                sd_mosi = frame[SD_FRAME_W-1];
                go      = 1'b1;
                if (half_done) state_next = ST_TX_HI;
            end
            ST_TX_HI: begin
                sd_cs_n = 1'b0;
                sd_sclk = 1'b1;
                sd_mosi = frame[SD_FRAME_W-1];
                go      = 1'b1;
                if (half_done) state_next = last_tx_bit ? ST_RX_LO : ST_TX_LO;
            end
            ST_RX_LO: begin
                sd_cs_n = 1'b0;
                go      = 1'b1;
                if (half_done) state_next = ST_RX_HI;
            end
            ST_RX_HI: begin
                sd_cs_n = 1'b0;
                sd_sclk = 1'b1;
                go      = 1'b1;
                if (half_done) begin
                    if (rx_bits == 3'd7 && (!rx_byte[7] || last_poll)) begin
                        state_next = ST_CS_HOLD;
                    end else begin
                        state_next = ST_RX_LO;
                    end
                end
            end
            ST_CS_HOLD: begin
                sd_cs_n = 1'b0;
                go      = 1'b1;
                if (half_done) state_next = ST_TRAIL_LO;
            end
            ST_TRAIL_LO: begin
                go = 1'b1;
                if (half_done) state_next = ST_TRAIL_HI;
            end
            ST_TRAIL_HI: begin
                sd_sclk = 1'b1;
                go      = 1'b1;
                if (half_done) state_next = (trail_cnt == 3'd7) ? ST_DONE : ST_TRAIL_LO;
            end
            ST_DONE: begin
                if (!start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame     <= '0;
            bit_cnt   <= '0;
            rx_bits   <= '0;
            rx_byte   <= SD_R1_IDLE;
            rx_taken  <= 1'b0;
            byte_cnt  <= '0;
            trail_cnt <= '0;
            finish    <= 1'b0;
            resp      <= SD_R1_IDLE;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame     <= sd_frame(cmd_index, cmd_arg, cmd_crc);
                        bit_cnt   <= '0;
                        rx_bits   <= '0;
                        byte_cnt  <= '0;
                        trail_cnt <= '0;
                        finish    <= 1'b0;
                        timeout   <= 1'b0;
                        resp      <= SD_R1_IDLE;
                    end
                end
                ST_TX_HI: begin
                    if (half_done) begin
                        frame   <= {frame[SD_FRAME_W-2:0], 1'b1};
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_RX_LO: begin
                    rx_taken <= 1'b0;
                end
                ST_RX_HI: begin
                    // MISO is taken once, in the first cycle SCLK is high.
                    if (!rx_taken) begin
                        rx_byte  <= {rx_byte[6:0], sd_miso};
                        rx_taken <= 1'b1;
                    end
                    if (half_done) begin
                        rx_bits <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7) begin
                            if (!rx_byte[7]) begin
                                resp <= rx_byte;
                            end else if (last_poll) begin
                                resp    <= SD_R1_IDLE;
                                timeout <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end
                    end
                end
                ST_TRAIL_HI: begin
                    if (half_done) begin
                        trail_cnt <= trail_cnt + 3'd1;
                        if (trail_cnt == 3'd7) finish <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Bench for sd_cmd_sender: timer model with stale finish, SD card model,
// SPI line monitor, directed commands with hand-computed expectations.
module tb_sd_cmd_sender;
    import sd_pkg::*;

    localparam int DELAY_W    = 4;
    localparam int HALF_TIMES = 4;
    localparam int RESP_POLL  = 8;

    // ---------------- clock / reset / signals ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               finish;
    logic [5:0]         cmd_index = '0;
    logic [31:0]        cmd_arg = '0;
    logic [6:0]         cmd_crc = '0;
    logic [7:0]         resp;
    logic               timeout;
    logic               sd_cs_n;
    logic               sd_sclk;
    logic               sd_mosi;
    logic               sd_miso = 1'b1;
    logic               delay_start;
    logic [DELAY_W-1:0] delay_times;
    logic               delay_finish = 1'b1;
    sd_state_e          fsm_state;

    always #5 clk = ~clk;

    sd_cmd_sender #(
        .DELAY_W    (DELAY_W),
        .HALF_TIMES (HALF_TIMES),
        .RESP_POLL  (RESP_POLL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .finish       (finish),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_crc      (cmd_crc),
        .resp         (resp),
        .timeout      (timeout),
        .sd_cs_n      (sd_cs_n),
        .sd_sclk      (sd_sclk),
        .sd_mosi      (sd_mosi),
        .sd_miso      (sd_miso),
        .delay_start  (delay_start),
        .delay_times  (delay_times),
        .delay_finish (delay_finish),
        .fsm_state    (fsm_state)
    );

    // ---------------- timer model ----------------
    // finish stays high (stale) for 3 cycles after a new request, then
    // drops, counts delay_times cycles and rises; sticky until re-request.
    int tm_phase = 0;
    int tm_cnt   = 0;

    always @(negedge clk) begin
        if (rst) begin
            tm_phase     = 0;
            delay_finish = 1'b1;
        end else begin
            case (tm_phase)
                0: if (delay_start) begin tm_cnt = 2; tm_phase = 1; end
                1: begin
                    if (tm_cnt == 0) begin
                        delay_finish = 1'b0;
                        tm_cnt       = int'(delay_times);
                        tm_phase     = 2;
                    end else tm_cnt--;
                end
                2: begin
                    if (tm_cnt == 0) begin
                        delay_finish = 1'b1;
                        tm_phase     = 3;
                    end else tm_cnt--;
                end
                default: if (!delay_start) tm_phase = 0;
            endcase
        end
    end

    // ---------------- card model and line monitor ----------------
    int          card_resp_at  = 0;   // 1-based byte holding R1; 0 = never
    logic [7:0]  card_resp_val = 8'hFF;

    function automatic logic card_bit(input int idx);
        logic [7:0] byte_v;
        byte_v = (card_resp_at != 0 && (idx / 8) == card_resp_at - 1) ? card_resp_val : 8'hFF;
        return byte_v[7 - (idx % 8)];
    endfunction

    int          total_rises = 0;
    int          cmd_rises   = 0;
    logic [47:0] tx_cap      = '0;
    logic        hi_mosi     = 1'b1;
    int          mosi_viol   = 0;
    int          half_run    = 0;
    int          min_half    = 1000;
    int          gap_run     = 0;
    int          gap_viol    = 0;
    logic        prev_sclk   = 1'b0;
    logic        prev_cs_n   = 1'b1;
    logic        prev_ds     = 1'b0;

    always @(negedge clk) begin
        if (prev_cs_n && !sd_cs_n) begin
            cmd_rises = 0;
            tx_cap    = '0;
        end
        if (!prev_sclk && sd_sclk) begin
            total_rises++;
            hi_mosi = sd_mosi;
            if (!sd_cs_n) begin
                if (cmd_rises < 48) tx_cap = {tx_cap[46:0], sd_mosi};
                cmd_rises++;
            end
        end else if (sd_sclk && sd_mosi !== hi_mosi) begin
            mosi_viol++;
        end
        // mode 0 card: next bit is presented after the falling edge
        if (sd_cs_n) sd_miso = 1'b1;
        else if (prev_sclk && !sd_sclk && cmd_rises >= 48) sd_miso = card_bit(cmd_rises - 48);
        // shortest SCLK level seen
        if (sd_sclk !== prev_sclk) begin
            if (half_run < min_half) min_half = half_run;
            half_run = 1;
        end else half_run++;
        // delay_start low gaps inside a command must be one cycle
        if (fsm_state == ST_IDLE || fsm_state == ST_DONE) gap_run = 0;
        else if (!delay_start) begin
            if (prev_ds || gap_run > 0) gap_run++;
        end else begin
            if (gap_run > 1) gap_viol++;
            gap_run = 0;
        end
        prev_sclk = sd_sclk;
        prev_cs_n = sd_cs_n;
        prev_ds   = delay_start;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_finish_level(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (finish !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, finish, lvl);
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input int resp_at, input logic [7:0] resp_val,
                           input bit hold, output int rises);
        int base;
        @(negedge clk);
        card_resp_at  = resp_at;
        card_resp_val = resp_val;
        cmd_index     = idx;
        cmd_arg       = arg;
        cmd_crc       = crc;
        base          = total_rises;
        start         = 1'b1;
        wait_finish_level(1'b0, 50, {tag, "_finish_clear"});
        if (!hold) begin
            repeat (5) @(negedge clk);
            start = 1'b0;
        end
        wait_finish_level(1'b1, 20000, {tag, "_finish_set"});
        rises = total_rises - base;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int rises;
        int base;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_finish", finish, 1'b0);
        check("rst_resp", resp, 8'hFF);
        check("rst_timeout", timeout, 1'b0);
        check("rst_cs_n", sd_cs_n, 1'b1);
        check("rst_sclk", sd_sclk, 1'b0);
        check("rst_mosi", sd_mosi, 1'b1);
        check("rst_delay_start", delay_start, 1'b0);
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_delay_times", delay_times, 4'd4);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0, R1 = 01 on second polled byte, start dropped mid-command
        run_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 2, 8'h01, 1'b0, rises);
        check("cmd0_mosi", tx_cap, 48'h40_00_00_00_00_95);
        check("cmd0_resp", resp, 8'h01);
        check("cmd0_timeout", timeout, 1'b0);
        check("cmd0_cmd_rises", cmd_rises, 48 + 16);
        check("cmd0_total_rises", rises, 48 + 16 + 8);
        repeat (3) @(negedge clk);
        check("cmd0_idle_state", fsm_state, ST_IDLE);
        check("cmd0_idle_finish", finish, 1'b1);

        // card never answers: timeout after RESP_POLL bytes, start held high
        run_cmd("tmo", 6'd0, 32'h0, 7'h4A, 0, 8'hFF, 1'b1, rises);
        check("tmo_resp", resp, 8'hFF);
        check("tmo_timeout", timeout, 1'b1);
        check("tmo_cmd_rises", cmd_rises, 48 + 64);
        check("tmo_total_rises", rises, 48 + 64 + 8);

        // start still high after finish: no second command
        base = total_rises;
        repeat (100) @(negedge clk);
        check("hold_state", fsm_state, ST_DONE);
        check("hold_finish", finish, 1'b1);
        check("hold_rises", total_rises - base, 0);
        check("hold_cs_n", sd_cs_n, 1'b1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_state", fsm_state, ST_IDLE);
        check("drop_finish", finish, 1'b1);

        // CMD8, R1 = 01 on the first polled byte
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h43, 1, 8'h01, 1'b0, rises);
        check("cmd8_mosi", tx_cap, 48'h48_00_00_01_AA_87);
        check("cmd8_resp", resp, 8'h01);
        check("cmd8_timeout", timeout, 1'b0);
        check("cmd8_total_rises", rises, 48 + 8 + 8);
        check("mosi_stable_high", mosi_viol, 0);
        check("min_half_ok", (min_half >= 6), 1'b1);
        check("gap_one_cycle", gap_viol, 0);

        // reset while the 20th command bit is on the wire
        @(negedge clk);
        card_resp_at = 1;
        card_resp_val = 8'h00;
        cmd_index = 6'd17;
        cmd_arg = 32'h0000_1234;
        cmd_crc = 7'h2A;
        start = 1'b1;
        begin
            int n;
            n = 0;
            while (!(sd_cs_n == 1'b0 && cmd_rises == 20) && n < 20000) begin
                @(negedge clk);
                n++;
            end
            check("mid_tx_reached", (n < 20000), 1'b1);
        end
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", sd_cs_n, 1'b1);
        check("midrst_sclk", sd_sclk, 1'b0);
        check("midrst_mosi", sd_mosi, 1'b1);
        check("midrst_delay_start", delay_start, 1'b0);
        check("midrst_state", fsm_state, ST_IDLE);
        check("midrst_finish", finish, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // recovery: CMD0 answered with R1 = 00 on the first byte
        run_cmd("recov", 6'd0, 32'h0, 7'h4A, 1, 8'h00, 1'b0, rises);
        check("recov_mosi", tx_cap, 48'h40_00_00_00_00_95);
        check("recov_resp", resp, 8'h00);
        check("recov_timeout", timeout, 1'b0);
        check("recov_total_rises", rises, 48 + 8 + 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
